// File: rtl/nibble_uart_tx.sv
// rtl/nibble_uart_tx.sv - nibble-FIFO fed UART 8N1 transmitter
//
// Pops two 4-bit nibbles from an upstream FIFO that has fixed read latency.
// The first nibble becomes the low half of the byte. The assembled byte is
// then sent as an 8N1 frame, LSB first.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          allows a new byte to start (looked at only in IDLE)
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream FIFO read nibble, valid RD_LATENCY cycles after a pop
//   fifo_rd_en  single-cycle pop request, never raised while fifo_empty=1
//   tx          registered serial line, idle high
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse on the last cycle of the stop bit
module nibble_uart_tx #(
  parameter int RD_LATENCY   = 4,   // >= 1
  parameter int CLKS_PER_BIT = 16   // 2..65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, POP_LO, WAIT_LO, POP_HI, WAIT_HI, START, DATA, STOP
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [LW-1:0] lat_cnt, lat_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [3:0]    lo_nib, lo_nib_n;
  logic          tx_q, tx_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      lat_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      lo_nib   <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      lat_cnt  <= lat_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      lo_nib   <= lo_nib_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    lat_cnt_n  = lat_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    lo_nib_n   = lo_nib;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;

    case (state)
      IDLE: begin
        if (en && !fifo_empty) state_n = POP_LO;
      end
      POP_LO: begin
        // The pop is gated by the live empty flag, so a starved FIFO just parks here.
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          lat_cnt_n  = '0;
          state_n    = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (lat_cnt == LAT_LAST) begin
          lo_nib_n = fifo_data;
          state_n  = POP_HI;
        end else begin
          lat_cnt_n = lat_cnt + 1'b1;
        end
      end
      POP_HI: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          lat_cnt_n  = '0;
          state_n    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (lat_cnt == LAT_LAST) begin
          shreg_n    = {fifo_data, lo_nib};
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = START;
        end else begin
          lat_cnt_n = lat_cnt + 1'b1;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        // The bit on the line is always shreg[0]. Shift only between bits,
        // so the last data bit stays put while STOP takes over the line.
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = shreg >> 1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          frame_done = 1'b1;
          baud_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is computed from the next state. It is registered on the same edge
  // as the state, so the line stays aligned with the FSM and glitch-free.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_nibble_uart_tx.sv
// tb/tb_nibble_uart_tx.sv - self-checking bench for nibble_uart_tx
module tb_nibble_uart_tx;

  localparam int LAT   = 4;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n, en, fifo_empty;
  logic [3:0] fifo_data;
  logic       fifo_rd_en, tx, busy, frame_done;

  always #5 clk = ~clk;

  nibble_uart_tx #(.RD_LATENCY(LAT), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vecs[5];

  int errors = 0;
  int checks = 0;

  logic [3:0] fq[$];
  logic [7:0] exp_q[$];
  logic [3:0] pipe[LAT];
  logic       pv[LAT];

  int         pops = 0, frames = 0, rx_cnt = 0, gap = 0, last_gap = 0;
  logic       rx_active = 1'b0;
  logic       rx_bit = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver and scoreboard, evaluated mid-cycle.
  task automatic monitor();
    int k, off;
    if (!rx_active) begin
      if (frame_done) chk("frame_done_outside_frame", int'(frame_done), 0);
      if (rst_n && !busy) gap++;
      if (rst_n && tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        last_gap  = gap;
      end
    end
    if (rx_active) begin
      k   = rx_cnt / CPB;
      off = rx_cnt % CPB;
      chk("busy_in_frame", int'(busy), 1);
      if (off == 0) rx_bit = tx;
      if (off == CPB - 1) begin
        chk("bit_hold", int'(tx), int'(rx_bit));
        if (k == 0)      chk("start_bit", int'(tx), 0);
        else if (k <= 8) rx_byte[k-1] = tx;
        else             chk("stop_bit", int'(tx), 1);
      end
      if (rx_cnt == FRAME - 1) begin
        chk("frame_done_at_end", int'(frame_done), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got 0x%0h expected none", rx_byte);
        end else begin
          chk("rx_byte", int'(rx_byte), int'(exp_q.pop_front()));
        end
        frames++;
        rx_active = 1'b0;
        gap       = 0;
      end else begin
        if (frame_done) chk("frame_done_early_at", rx_cnt, FRAME - 1);
        rx_cnt++;
      end
    end
  endtask

  // One clock: observe at negedge, then update the FIFO model just after posedge.
  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = fifo_rd_en;
    if (rd) chk("rd_while_empty", int'(fifo_empty), 0);
    monitor();
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pipe[i] = pipe[i-1];
      pv[i]   = pv[i-1];
    end
    pipe[0] = 4'h0;
    pv[0]   = 1'b0;
    if (rd) begin
      pops++;
      if (fq.size() > 0) begin
        pipe[0] = fq.pop_front();
        pv[0]   = 1'b1;
      end
    end
    fifo_data  = pv[LAT-1] ? pipe[LAT-1] : 4'($urandom);
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [3:0] n);
    fq.push_back(n);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 4000) begin
      tick();
      n++;
    end
    chk("frame_timeout", frames, target);
  endtask

  task automatic wait_pos(input int pos);
    int n = 0;
    while (!(rx_active && rx_cnt == pos) && n < 4000) begin
      tick();
      n++;
    end
    chk("wait_pos_timeout", int'(rx_active && rx_cnt == pos), 1);
  endtask

  initial begin
    int p0;
    vecs[0] = '{4'h5, 4'hA, 8'hA5};
    vecs[1] = '{4'h0, 4'h0, 8'h00};
    vecs[2] = '{4'hF, 4'hF, 8'hFF};
    vecs[3] = '{4'h6, 4'h9, 8'h96};
    vecs[4] = '{4'h1, 4'h8, 8'h81};
    for (int i = 0; i < LAT; i++) begin
      pipe[i] = 4'h0;
      pv[i]   = 1'b0;
    end
    rst_n = 1'b0;
    en = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = 4'h0;

    // Reset state.
    repeat (3) tick();
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_en", int'(fifo_rd_en), 0);
    chk("reset_frame_done", int'(frame_done), 0);

    // Idle with an empty FIFO and en high.
    rst_n = 1'b1;
    en = 1'b1;
    p0 = pops;
    repeat (100) tick();
    chk("idle_pops", pops - p0, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_tx", int'(tx), 1);

    // Table of single bytes.
    foreach (vecs[i]) begin
      p0 = pops;
      push(vecs[i].lo);
      push(vecs[i].hi);
      exp_q.push_back(vecs[i].exp_byte);
      wait_frames(frames + 1);
      chk("vec_pops", pops - p0, 2);
    end

    // High nibble starved for 50 cycles.
    repeat (5) tick();
    p0 = pops;
    push(4'h3);
    exp_q.push_back(8'hC3);
    repeat (50) tick();
    chk("starved_pops", pops - p0, 1);
    chk("starved_busy", int'(busy), 1);
    chk("starved_tx", int'(tx), 1);
    push(4'hC);
    wait_frames(frames + 1);
    chk("starved_total_pops", pops - p0, 2);

    // Back-to-back bytes.
    repeat (5) tick();
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h43);
    wait_frames(frames + 2);
    chk("b2b_idle_gap", last_gap, 1);

    // en dropped during DATA with FIFO still holding a byte.
    repeat (5) tick();
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h43);
    wait_pos(2 * CPB + 2);
    en = 1'b0;
    wait_frames(frames + 1);
    p0 = pops;
    repeat (60) tick();
    chk("en_drop_pops", pops - p0, 0);
    chk("en_drop_busy", int'(busy), 0);
    chk("en_drop_tx", int'(tx), 1);
    en = 1'b1;
    wait_frames(frames + 1);
    chk("en_resume_pops", pops - p0, 2);

    // Reset during data bit 3.
    repeat (5) tick();
    push(4'h5); push(4'hA);
    exp_q.push_back(8'hA5);
    wait_pos(4 * CPB + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_tx", int'(tx), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_rd_en", int'(fifo_rd_en), 0);
    rx_active = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_busy", int'(busy), 0);
    p0 = pops;
    push(4'h7); push(4'h8);
    exp_q.push_back(8'h87);
    wait_frames(frames + 1);
    chk("post_reset_pops", pops - p0, 2);
    repeat (5) tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_uart_tx.md
NIBBLE_UART_TX -- requirements
Module: nibble_uart_tx

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 4: cycles from fifo_rd_en high to fifo_data valid.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit, legal range 2..65535.
REQ-003 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port en, input, 1: permits starting a new byte when high.
REQ-006 SHALL have port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-007 SHALL have port fifo_data, input, 4: upstream FIFO read data nibble.
REQ-008 SHALL have port fifo_rd_en, output, 1: single-cycle pop request to upstream FIFO.
REQ-009 SHALL have port tx, output, 1: UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, POP_LO, WAIT_LO, POP_HI, WAIT_HI, START, DATA, STOP.
REQ-013 IDLE: if en=1 and fifo_empty=0, SHALL go to POP_LO the next cycle; otherwise stay.
REQ-014 POP_LO/POP_HI: SHALL assert fifo_rd_en for exactly one cycle when fifo_empty=0, then go to WAIT_LO/WAIT_HI; if fifo_empty=1, SHALL hold the state with fifo_rd_en=0.
REQ-015 fifo_rd_en SHALL never be high while fifo_empty=1, and never high in any state except POP_LO/POP_HI.
REQ-016 WAIT_x: SHALL count RD_LATENCY cycles after the pop cycle, then sample fifo_data on that cycle (low nibble in WAIT_LO, high nibble in WAIT_HI).
REQ-017 Byte assembly: byte = {high nibble, low nibble}; first nibble popped is bits [3:0].
REQ-018 After WAIT_LO, SHALL go to POP_HI regardless of en; a started byte is always completed.
REQ-019 After WAIT_HI, SHALL go to START with the assembled byte loaded into the shift register.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles.
REQ-021 DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit counter, baud counter sized for CLKS_PER_BIT.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 on the final cycle; then IDLE.
REQ-023 Frame length from START entry to STOP exit SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-024 tx SHALL be 1 in IDLE, POP_x, WAIT_x; tx SHALL be registered (glitch-free).
REQ-025 en falling mid-byte (any non-IDLE state) SHALL NOT abort or stretch the frame; en is checked only in IDLE.
REQ-026 Back-to-back: with en=1 and FIFO non-empty, IDLE SHALL last exactly one cycle between frames.
REQ-027 fifo_data SHALL be ignored in all cycles other than the sample cycles in REQ-016.

Reset
REQ-028 While rst_n=0: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, counters and shift register 0, all asynchronously.
REQ-029 Reset mid-frame SHALL drive tx=1 immediately; partial byte and any outstanding pop are discarded (no recovery of popped nibbles).
REQ-030 After rst_n deasserts, the first state change SHALL occur no earlier than the first rising clk edge.

Verification (RD_LATENCY=4, CLKS_PER_BIT=16)
REQ-031 Idle/reset: rst_n=0 then 1, fifo_empty=1, en=1 for 100 cycles -> tx=1, busy=0, fifo_rd_en never high.
REQ-032 Single byte: FIFO supplies nibbles 0x5 then 0xA -> two fifo_rd_en pulses, tx sends 0xA5 (bits 1,0,1,0,0,1,0,1 after start), 160-cycle frame, one frame_done pulse.
REQ-033 Starved high nibble: FIFO holds only 0x3, refilled with 0xC 50 cycles later -> FSM holds POP_HI, tx stays 1, then transmits 0xC3.
REQ-034 Back-to-back: FIFO holds 0x1,0x2,0x3,0x4 -> bytes 0x21 then 0x43, exactly one IDLE cycle between frames, two frame_done pulses.
REQ-035 en drop: en=0 asserted in DATA of byte 0x21 with FIFO non-empty -> 0x21 completes fully, no further fifo_rd_en until en=1.
REQ-036 Reset mid-DATA: rst_n=0 during bit 3 -> tx=1 and busy=0 in the same cycle; after release with 0x7,0x8 queued, clean 0x87 frame.
